// File: rtl/muldiv_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_sched                                           |
// | Description : 32-iteration shift-add mult/multu unit with HI/LO      |
// |               registers, mthi/mtlo writes and pipeline stall output. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module muldiv_sched (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        rd_req,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;
  localparam logic [4:0] c_last_iter = 5'd31;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_neg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_launch;
  logic        w_idle_wr;
  logic [63:0] w_acc_add;
  logic [63:0] w_result;

  // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
  assign w_mag_a   = (is_signed & src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign w_mag_b   = (is_signed & src_b[31]) ? (~src_b + 32'd1) : src_b;
  assign w_launch  = (r_state == c_st_idle) & start & ~flush;
  assign w_idle_wr = (r_state == c_st_idle) & ~start & ~flush;
  assign w_acc_add = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
  assign w_result  = r_neg ? (~r_acc + 64'd1) : r_acc;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_launch) begin
          w_next = c_st_calc;
        end
      end
      c_st_calc: begin
        if (flush) begin
          w_next = c_st_idle;
        end else if (r_cnt == c_last_iter) begin
          w_next = c_st_done;
        end
      end
      c_st_done: begin
        w_next = c_st_idle;
      end
      default: begin
        w_next = c_st_idle;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (r_state == c_st_calc) | (r_state == c_st_done);
    done  = (r_state == c_st_done);
    stall = busy & (start | rd_req | hi_we | lo_we);
  end

  // Multiplier datapath: multiplicand shifts left while multiplier shifts right.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_acc    <= 64'd0;
      r_cnt    <= 5'd0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_launch) begin
            r_mcand  <= {32'd0, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_neg    <= is_signed & (src_a[31] ^ src_b[31]);
          end
        end
        c_st_calc: begin
          r_acc    <= w_acc_add;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO: updated only by mthi/mtlo in IDLE or by an unflushed completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if ((r_state == c_st_done) && !flush) begin
      r_hi <= w_result[63:32];
      r_lo <= w_result[31:0];
    end else if (w_idle_wr) begin
      if (hi_we) begin
        r_hi <= wdata;
      end
      if (lo_we) begin
        r_lo <= wdata;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_muldiv_sched                                        |
// | Description : Directed self-checking bench for muldiv_sched.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_muldiv_sched;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        is_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        rd_req;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sched dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .is_signed (is_signed),
    .src_a     (src_a),
    .src_b     (src_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .rd_req    (rd_req),
    .flush     (flush),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // hook: 0 none, 1 hold rd_req from the cycle after start, 2 pulse mthi during CALC
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic we_with_start, input int hook,
                        input logic [63:0] expv);
    int k;
    int stall_low;
    stall_low = 0;
    @(negedge clk);
    start = 1'b1; is_signed = s; src_a = a; src_b = b;
    hi_we = we_with_start; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk({tag, " busy"}, {63'd0, busy}, 64'd1);
    k = 1;
    while (k < 40) begin
      if (hook == 1) rd_req = 1'b1;
      if (hook == 2) begin
        hi_we = (k == 5);
        wdata = 32'h12345678;
      end
      #1;
      if (hook == 1 && !stall) stall_low++;
      if (hook == 2 && k == 5) chk({tag, " stall on mthi"}, {63'd0, stall}, 64'd1);
      if (done) break;
      @(negedge clk);
      k++;
    end
    hi_we = 1'b0;
    chk({tag, " latency"}, k, 64'd33);
    if (hook == 1) chk({tag, " stall while busy"}, stall_low, 64'd0);
    @(negedge clk);
    #1;
    chk({tag, " done pulse"}, {63'd0, done}, 64'd0);
    if (hook == 1) begin
      chk({tag, " stall after"}, {63'd0, stall}, 64'd0);
      rd_req = 1'b0;
    end
    chk({tag, " result"}, {hi, lo}, expv);
  endtask

  initial begin
    int k;
    int done_seen;
    resetn = 1'b0; start = 1'b1; is_signed = 1'b0; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rd_req = 1'b1; flush = 1'b0;

    // Reset state
    #12;
    chk("reset busy",  {63'd0, busy},  64'd0);
    chk("reset done",  {63'd0, done},  64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);
    chk("reset hilo",  {hi, lo},       64'd0);
    @(negedge clk);
    resetn = 1'b1; start = 1'b0; rd_req = 1'b0;

    // Products
    do_mul("multu max",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 64'hFFFFFFFE_00000001);
    do_mul("mult -3x5",   32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b0, 0, 64'hFFFFFFFF_FFFFFFF1);
    do_mul("mult min^2",  32'h80000000, 32'h80000000, 1'b1, 1'b0, 0, 64'h40000000_00000000);
    do_mul("mult 7x-2",   32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 0, 64'hFFFFFFFF_FFFFFFF2);
    do_mul("multu 2^31x2", 32'h80000000, 32'h00000002, 1'b0, 1'b0, 0, 64'h00000001_00000000);
    do_mul("rd stall",    32'h00000003, 32'h00000004, 1'b0, 1'b0, 1, 64'h00000000_0000000C);
    do_mul("mthi busy",   32'h00010000, 32'h00030000, 1'b0, 1'b0, 2, 64'h00000003_00000000);
    do_mul("start prio",  32'h00000002, 32'h00000003, 1'b0, 1'b1, 0, 64'h00000000_00000006);

    // mthi/mtlo together, then separately
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00000055;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi+mtlo", {hi, lo}, 64'h00000055_00000055);
    hi_we = 1'b1; wdata = 32'hAAAA0000;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000BBBB;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mthi mtlo", {hi, lo}, 64'hAAAA0000_0000BBBB);

    // Flush in IDLE blocks start and writes
    flush = 1'b1; start = 1'b1; hi_we = 1'b1; wdata = 32'h11111111;
    src_a = 32'd5; src_b = 32'd5; is_signed = 1'b0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0; hi_we = 1'b0;
    chk("idle flush busy", {63'd0, busy}, 64'd0);
    chk("idle flush hilo", {hi, lo}, 64'hAAAA0000_0000BBBB);

    // Flush at the 10th CALC cycle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("calc flush busy", {63'd0, busy}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("calc flush no done", done_seen, 64'd0);
    chk("calc flush hilo", {hi, lo}, 64'hAAAA0000_0000BBBB);

    // Asynchronous reset mid-CALC
    start = 1'b1; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k < 6; k++) @(negedge clk);
    rd_req = 1'b1;
    #1;
    chk("pre-reset stall", {63'd0, stall}, 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async rst busy",  {63'd0, busy},  64'd0);
    chk("async rst stall", {63'd0, stall}, 64'd0);
    chk("async rst hilo",  {hi, lo},       64'd0);
    @(negedge clk);
    resetn = 1'b1; rd_req = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("post reset idle", done_seen, 64'd0);
    chk("post reset hilo", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL: start  in  1  request to begin a mult/multu operation (decoded ALUOp 13).
REQ-004 SHALL: is_signed  in  1  1 = mult (two's complement), 0 = multu.
REQ-005 SHALL: src_a  in  32  multiplicand (rs).
REQ-006 SHALL: src_b  in  32  multiplier (rt).
REQ-007 SHALL: hi_we  in  1  mthi write request.
REQ-008 SHALL: lo_we  in  1  mtlo write request.
REQ-009 SHALL: wdata  in  32  data for hi_we/lo_we.
REQ-010 SHALL: rd_req  in  1  mfhi/mflo read request.
REQ-011 SHALL: flush  in  1  abort any in-flight operation.
REQ-012 SHALL: busy  out  1  high in CALC and DONE.
REQ-013 SHALL: stall  out  1  pipeline hold request.
REQ-014 SHALL: done  out  1  one-cycle completion pulse.
REQ-015 SHALL: hi  out  32  HI register; lo  out  32  LO register.

Function
REQ-016 SHALL: FSM states IDLE, CALC, DONE; the encoding is internal.
REQ-017 SHALL: in IDLE with start=1 and flush=0, latch |src_a| and |src_b| (magnitudes when is_signed=1, raw otherwise), latch the result sign = is_signed & (a[31]^b[31]), clear the 64-bit accumulator, set the 5-bit counter to 0, and go to CALC.
REQ-018 SHALL: in CALC, perform one shift-add iteration per cycle (add the shifted multiplicand when the current multiplier bit = 1), then increment the counter.
REQ-019 SHALL: go from CALC to DONE on the edge where counter = 31, giving exactly 32 iterations.
REQ-020 SHALL: in DONE, assert done=1; on the next edge, write {hi,lo} with the accumulator (two's-complement negated if the result sign = 1) and return to IDLE.
REQ-021 SHALL: meet this latency: start sampled at edge E0, done high between E32 and E33, new hi/lo visible after E33.
REQ-022 SHALL: treat magnitude 0x80000000 as unsigned 2^31; the full 64-bit result is exact for all operands.
REQ-023 SHALL: drive stall = busy & (start | rd_req | hi_we | lo_we) combinationally.
REQ-024 SHALL: ignore hi_we, lo_we and start while busy=1.
REQ-025 SHALL: in IDLE, write hi/lo from wdata on the next edge when hi_we/lo_we=1; both may be set in the same cycle.
REQ-026 SHALL: give start priority when start and hi_we/lo_we are high in the same IDLE cycle; the writes are dropped.
REQ-027 SHALL: when flush=1 in CALC or DONE, go to IDLE on the next edge, leave hi/lo unchanged, and suppress done in following cycles.
REQ-028 SHALL: when flush=1 in IDLE, ignore start, hi_we and lo_we.
REQ-029 SHALL: keep hi/lo readable at all times; values change only per REQ-020/REQ-025.

Reset
REQ-030 SHALL: while resetn=0, immediately force state=IDLE, hi=lo=0, counter=0, accumulator=0, and busy=done=0.
REQ-031 SHALL: while resetn=0, drive stall=0.
REQ-032 SHALL: discard an in-flight operation when reset occurs mid-operation; no done pulse follows the release of reset.

Verification
REQ-033 SHALL: multu 0xFFFFFFFF x 0xFFFFFFFF -> done exactly one cycle after 32 CALC cycles; hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 SHALL: mult 0xFFFFFFFD x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-035 SHALL: rd_req=1 held from the cycle after start -> stall=1 through the DONE cycle and stall=0 after E33; hi/lo then hold the new product.
REQ-036 SHALL: hi_we=1 with wdata=0x12345678 during CALC -> stall=1 and the write is ignored; after completion hi equals the product high word.
REQ-037 SHALL: flush=1 at the 10th CALC cycle -> IDLE next cycle, no done pulse, hi/lo keep their prior values (e.g. 0xAAAA0000/0x0000BBBB from a preceding mthi/mtlo).
REQ-038 SHALL: resetn=0 asserted mid-CALC -> busy, stall, hi and lo read 0 within the same cycle without a clock edge; no done pulse after the release of reset.
